srff_access_arbiter: RTL
========================

// Module: srff_access_arbiter
// PURPOSE
//   Shares one SRFF flag between N_REQ requesters. Each requester asks to set or clear
//   the flag; the arbiter grants one request at a time in round-robin order and drives
//   single-cycle S or R pulses, never both. It reads back Q, acks the requester and
//   flags mismatches. Sits between client FSMs and the SRFF instance.
// PARAMETERS
//   N_REQ   4   number of requesters (2..8)
//   CNT_W   8   width of the saturating pulse counter
// PORTS
//   clk        in   1       system clock, all logic on posedge
//   rst_n      in   1       synchronous active-low reset
//   req        in   N_REQ   request per client; held high until its ack
//   op         in   N_REQ   per-client operation: 1 = set, 0 = clear; stable while req high
//   q_in       in   1       Q fed back from the SRFF
//   S          out  1       set pulse to the SRFF (registered)
//   R          out  1       reset pulse to the SRFF (registered)
//   ack        out  N_REQ   one-hot, one-cycle completion pulse to the granted client
//   grant_id   out  $clog2(N_REQ)  index of the current or last winner
//   busy       out  1       high whenever state != IDLE
//   pulse_cnt  out  CNT_W   number of S/R pulses issued; saturates at all-ones
//   err        out  1       sticky: Q read back differs from the requested op
// BEHAVIOUR
//   Clock and reset
//   - One clock. Reset is synchronous and active-low.
//   - When rst_n = 0 at a posedge: state = IDLE, S = R = 0, ack = 0, grant_id = 0,
//     rr_ptr = 0, busy = 0, pulse_cnt = 0, err = 0.
//   - Reset mid-operation aborts the request: no ack is issued and any pending pulse is
//     dropped. The requester re-arbitrates after reset releases.
//   FSM
//   - IDLE -> ISSUE when any req bit is high.
//     The winner is the first set bit at or after rr_ptr, wrapping modulo N_REQ.
//     Latch the winner index into grant_id, latch op[winner], and set rr_ptr = winner+1
//     (wraps).
//   - ISSUE (1 cycle): S = op_l & (q_in != op_l); R = ~op_l & (q_in != op_l).
//     If q_in already equals op_l, no pulse is issued.
//     pulse_cnt increments only when S or R is asserted.
//   - ISSUE -> ACK, unconditional.
//   - ACK (1 cycle): S = R = 0, ack[grant_id] = 1.
//     If q_in != op_l, err is set at the end of this cycle.
//   - ACK -> IDLE, unconditional.
//   Invariants and timing
//   - S and R are never high in the same cycle.
//   - Each of S and R is high for at most one cycle per grant.
//   - Latency: req seen in cycle t -> pulse in t+1 -> ack in t+2 -> IDLE in t+3.
//     Throughput is one operation per 3 cycles; back-to-back requests are re-arbitrated
//     in IDLE.
//   Boundary conditions
//   - Simultaneous requests: strict round-robin; no client waits more than N_REQ grants.
//   - A client that drops req before its ack: the operation still completes and the
//     ack still pulses.
//   - A client that holds req after its ack: treated as a new request; rr_ptr has
//     already moved past it.
//   - op changing while req is high: ignored after the grant; op_l is used.
//   - pulse_cnt saturates at 2^CNT_W-1 and does not wrap.
//   - err clears only on reset.
// TESTING
//   1. Reset, then req=0001, op=0001, q_in=0 -> S=1 in cycle 2, ack=0001 in cycle 3,
//      pulse_cnt=1, err=0.
//   2. req=1111 held continuously -> grant_id sequence 0,1,2,3,0; one ack per 3 cycles;
//      S&R never 1.
//   3. q_in=1 with a set request -> no S pulse, ack still issued, pulse_cnt unchanged.
//   4. Clear request with the model holding q_in=1 through ACK -> err=1; it stays 1
//      until rst_n=0.
//   5. rst_n=0 during ISSUE -> next cycle S=R=0, no ack, pulse_cnt=0, busy=0.
//   6. CNT_W=2, 5 real pulses -> pulse_cnt stays at 3.

Source files
------------

// File: rtl/srff_access_arbiter.sv
// srff_access_arbiter
//   Shares one SR flip-flop between N_REQ client FSMs. Requests are granted one at a
//   time in round-robin order. Each grant runs IDLE -> ISSUE -> ACK -> IDLE:
//   - ISSUE carries a single-cycle S or R pulse, and only when Q differs from the
//     requested value.
//   - ACK pulses ack for the winner, and err latches if the read-back Q is still wrong.
//
// Ports
//   clk        system clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   req        per-client request, held until ack
//   op         per-client operation (1 = set, 0 = clear), captured at grant
//   q_in       Q fed back from the SRFF
//   S, R       registered set / reset pulses, mutually exclusive
//   ack        one-hot, one-cycle completion pulse to the granted client
//   grant_id   index of the current or last winner
//   busy       high whenever the FSM is not in IDLE
//   pulse_cnt  count of S/R pulses issued, saturating at all-ones
//   err        sticky read-back mismatch flag, cleared only by reset
module srff_access_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         op,
    input  logic                     q_in,
    output logic                     S,
    output logic                     R,
    output logic [N_REQ-1:0]         ack,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         pulse_cnt,
    output logic                     err
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] win_nxt;
    logic            win_op;
    logic            need_pulse;
    logic            op_l;

    // First requesting client at or after the pointer, wrapping modulo N_REQ.
    function automatic logic [ID_W-1:0] pick(input logic [N_REQ-1:0] r,
                                             input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] w;
        logic            found;
        idx   = p;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
            idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
        return w;
    endfunction

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        win        = pick(req, rr_ptr);
        win_op     = op[win];
        need_pulse = (q_in != win_op);
        win_nxt    = (win == ID_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end

    assign busy = (state != IDLE);

    // S/R are registered, so the pulse value is decided on the grant edge
    // and appears on the outputs for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            S         <= 1'b0;
            R         <= 1'b0;
            ack       <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
            pulse_cnt <= '0;
            err       <= 1'b0;
        end else begin
            S   <= 1'b0;
            R   <= 1'b0;
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_id <= win;
                        rr_ptr   <= win_nxt;
                        S        <= win_op & need_pulse;
                        R        <= ~win_op & need_pulse;
                        if (need_pulse) begin
                            pulse_cnt <= sat_inc(pulse_cnt);
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack   <= N_REQ'(1) << grant_id;
                    state <= ACK;
                end
                ACK: begin
                    if (q_in != op_l) begin
                        err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operation latched at grant; later changes on op are ignored for this grant.
    always_ff @(posedge clk) begin
        if (state == IDLE && (|req)) begin
            op_l <= win_op;
        end
    end

endmodule
